data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store path. It accepts one load or store request at a time from the execute stage over a valid/ready handshake, services it against an internal byte-lane word memory after a configurable number of wait states, and returns the load bytes right-aligned to lane 0 with a fault flag. The execute stage performs the sign/zero extension. This block does lane selection, byte-enable writes, alignment and range checks.

---
 rtl/data_mem_responder_pkg.sv | 49 ++++
 rtl/byte_lane_sram.sv | 36 +++
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 tb/tb_data_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder: funct3 codes,
// FSM state encoding, byte lanes and the request legality check.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef logic [7:0] byte_t;
    typedef logic [3:0][7:0] word_lanes_t;

    // Lanes covered by an access of the given size code (funct3[1:0]).
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic access_fault(input logic        write,
                                          input logic [2:0]  f3,
                                          input logic [31:0] addr,
                                          input int unsigned depth_words);
        logic code_bad;
        logic align_bad;
        logic range_bad;
        if (write) begin
            code_bad = !(f3 inside {F3_B, F3_H, F3_W});
        end else begin
            code_bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        align_bad = ((f3 == F3_H || f3 == F3_HU) && addr[0])
                  || (f3 == F3_W && addr[1:0] != 2'b00);
        range_bad = {2'b00, addr[31:2]} >= depth_words;
        return code_bad | align_bad | range_bad;
    endfunction

endpackage

// File: rtl/byte_lane_sram.sv
// Word-organised memory with one write enable per byte lane and a registered
// read port. Contents are intentionally not reset.
module byte_lane_sram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  word_lanes_t       wdata_i,
    output word_lanes_t       rdata_o
);

    word_lanes_t mem_q [DEPTH_WORDS];
    word_lanes_t rdata_q;

    // A store leaves the read register alone so the last load stays visible.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][i] <= wdata_i[i];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request at a time, commits it to the
// byte-lane memory after WAIT_CYCLES wait states and returns right-aligned load bytes.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output byte_t       rsp_rdata [0:3],
    output logic        rsp_fault,
    output mem_state_t  dbg_state
);

    // Handshakes: a request transfers on the rising edge where req_valid and
    // req_ready are both high; a response transfers where rsp_valid and rsp_ready are.
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic              fault_q;

    logic              req_fault;
    logic              commit;
    logic [ADDR_W+1:0] cur_addr;
    logic [1:0]        cur_size;
    logic              cur_write;
    logic [31:0]       cur_wdata;
    logic [3:0]        mem_we;
    word_lanes_t       mem_wdata;
    word_lanes_t       mem_rdata;
    logic [31:0]       load_shifted;
    logic [3:0]        load_mask;
    logic              load_out;

    assign req_fault = access_fault(req_write, req_funct3, req_addr, DEPTH_WORDS);

    // With no wait states the commit uses the request fields on the acceptance edge;
    // otherwise it uses the latched copy when the counter expires.
    always_comb begin
        cur_addr  = addr_q;
        cur_size  = size_q;
        cur_write = write_q;
        cur_wdata = wdata_q;
        commit    = 1'b0;
        if (state_q == IDLE) begin
            cur_addr  = req_addr[ADDR_W+1:0];
            cur_size  = req_funct3[1:0];
            cur_write = req_write;
            cur_wdata = req_wdata;
            commit    = req_valid && !req_fault && (WAIT_CYCLES == 0);
        end else if (state_q == WAIT) begin
            commit    = (cnt_q == '0);
        end
    end

    always_comb begin
        mem_we    = 4'b0000;
        mem_wdata = word_lanes_t'(cur_wdata << {cur_addr[1:0], 3'b000});
        if (commit && cur_write) begin
            mem_we = 4'(size_mask(cur_size) << cur_addr[1:0]);
        end
    end

    byte_lane_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .en_i    (commit),
        .we_i    (mem_we),
        .addr_i  (cur_addr[ADDR_W+1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[ADDR_W+1:0];
                        size_q  <= req_funct3[1:0];
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        fault_q <= req_fault;
                        if (req_fault || WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_LOAD;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The read register only changes on a load commit, so the response stays stable while stalled.
    assign load_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    assign load_mask    = size_mask(size_q);
    assign load_out     = (state_q == RESP) && !fault_q && !write_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rsp_rdata[i] = (load_out && load_mask[i]) ? load_shifted[8*i +: 8] : 8'h00;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_fault = fault_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with one wait state for the
// main traffic, a second with three wait states for the mid-wait reset case.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst3_n;
    logic        req_valid, req_write, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready1, rsp_valid1, rsp_fault1;
    logic [7:0]  rd1 [0:3];
    mem_state_t  st1;
    logic        req_ready3, rsp_valid3, rsp_fault3;
    logic [7:0]  rd3 [0:3];
    mem_state_t  st3;

    logic        use3;
    logic        m_req_ready, m_rsp_valid, m_rsp_fault;
    logic [31:0] m_rdata;
    logic [1:0]  m_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_rdata(rd1), .rsp_fault(rsp_fault1), .dbg_state(st1)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(req_valid), .req_ready(req_ready3),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
        .rsp_rdata(rd3), .rsp_fault(rsp_fault3), .dbg_state(st3)
    );

    always_comb begin
        if (use3) begin
            m_req_ready = req_ready3;
            m_rsp_valid = rsp_valid3;
            m_rsp_fault = rsp_fault3;
            m_rdata     = {rd3[3], rd3[2], rd3[1], rd3[0]};
            m_state     = st3;
        end else begin
            m_req_ready = req_ready1;
            m_rsp_valid = rsp_valid1;
            m_rsp_fault = rsp_fault1;
            m_rdata     = {rd1[3], rd1[2], rd1[1], rd1[0]};
            m_state     = st1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " req_ready"}, {31'b0, m_req_ready}, 32'd1);
        check_eq({tag, " rsp_valid"}, {31'b0, m_rsp_valid}, 32'd0);
        check_eq({tag, " rsp_fault"}, {31'b0, m_rsp_fault}, 32'd0);
        check_eq({tag, " rsp_rdata"}, m_rdata, 32'd0);
        check_eq({tag, " state"}, {30'b0, m_state}, {30'b0, IDLE});
    endtask

    // Called just after a rising edge; returns just after the response handshake edge.
    task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_fault,
                          input int exp_lat);
        int lat;
        logic seen;
        logic [31:0] exp_word;
        exp_q.push_back(exp_data);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_req_ready;
        end
        check_eq({tag, " accepted"}, {31'b0, seen}, 32'd1);
        if (!seen) begin
            req_valid = 1'b0;
            exp_word = exp_q.pop_front();
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = m_rsp_valid;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        exp_word = exp_q.pop_front();
        if (!seen) return;
        check_eq({tag, " fault"}, {31'b0, m_rsp_fault}, {31'b0, exp_fault});
        check_eq({tag, " rdata"}, m_rdata, exp_word);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        use3       = 1'b0;
        rst_n      = 1'b0;
        rst3_n     = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset1");
        @(posedge clk);
        #1;

        access("sw 10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        access("lw 10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        access("sw 20", 1'b1, F3_W, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
        access("sb 21", 1'b1, F3_B, 32'h21, 32'hFFFFFF11, 32'h0, 1'b0, 2);
        access("sh 22", 1'b1, F3_H, 32'h22, 32'hFFFF2233, 32'h0, 1'b0, 2);
        access("lw 20", 1'b0, F3_W, 32'h20, 32'h0, 32'h223311A5, 1'b0, 2);

        access("sw 30",  1'b1, F3_W,  32'h30, 32'h80FF7F01, 32'h0, 1'b0, 2);
        access("lb 31",  1'b0, F3_B,  32'h31, 32'h0, 32'h0000007F, 1'b0, 2);
        access("lhu 32", 1'b0, F3_HU, 32'h32, 32'h0, 32'h000080FF, 1'b0, 2);
        access("lh 30",  1'b0, F3_H,  32'h30, 32'h0, 32'h00007F01, 1'b0, 2);
        access("lbu 33", 1'b0, F3_BU, 32'h33, 32'h0, 32'h00000080, 1'b0, 2);

        access("sw 40", 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        access("f lw 42", 1'b0, F3_W, 32'h42, 32'h0, 32'h0, 1'b1, 1);
        access("lw 40 a", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        access("f sh 41", 1'b1, F3_H, 32'h41, 32'h11112222, 32'h0, 1'b1, 1);
        access("lw 40 b", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        access("f sw f3=4", 1'b1, 3'd4, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        access("lw 40 c", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        access("f lw range", 1'b0, F3_W, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
        access("f sb range", 1'b1, F3_B, 32'h1000, 32'h55, 32'h0, 1'b1, 1);
        access("lw 40 d", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2);

        // Backpressure: stall the response, hold a second request behind it.
        req_write  = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        req_valid  = 1'b1;
        rsp_ready  = 1'b0;
        @(negedge clk);
        check_eq("bp ready", {31'b0, m_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_addr = 32'h30;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_rsp_valid;
        end
        check_eq("bp rsp seen", {31'b0, seen}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp stall valid", {31'b0, m_rsp_valid}, 32'd1);
            check_eq("bp stall rdata", m_rdata, 32'hDEADBEEF);
            check_eq("bp stall fault", {31'b0, m_rsp_fault}, 32'd0);
            check_eq("bp stall ready", {31'b0, m_req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("bp after hs valid", {31'b0, m_rsp_valid}, 32'd0);
        check_eq("bp after hs ready", {31'b0, m_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("bp 2nd accepted", {31'b0, m_req_ready}, 32'd0);
        @(negedge clk);
        check_eq("bp 2nd valid", {31'b0, m_rsp_valid}, 32'd1);
        check_eq("bp 2nd rdata", m_rdata, 32'h80FF7F01);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of the wait states on the three-wait-state instance.
        rst_n = 1'b0;
        use3  = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset3");
        @(posedge clk);
        #1;
        rst3_n = 1'b1;
        access("w3 sw 50", 1'b1, F3_W, 32'h50, 32'h11223344, 32'h0, 1'b0, 4);
        access("w3 lw 50", 1'b0, F3_W, 32'h50, 32'h0, 32'h11223344, 1'b0, 4);
        req_write  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h50;
        req_wdata  = 32'h12345678;
        req_valid  = 1'b1;
        @(negedge clk);
        check_eq("w3 abort ready", {31'b0, m_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("w3 abort in wait", {30'b0, m_state}, {30'b0, WAIT});
        @(posedge clk);
        #1;
        rst3_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("w3 mid reset");
        @(posedge clk);
        #1;
        rst3_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("w3 no late rsp", {31'b0, m_rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        access("w3 lw after rst", 1'b0, F3_W, 32'h50, 32'h0, 32'h11223344, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
